// File: rtl/arm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arm_pkg
// Brief    : Shared widths, fetch FSM states and fetch-buffer entry type.
// Revision : 1.0 - initial release
// ============================================================================
package arm_pkg;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;
    localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(3);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Small synchronous FIFO of fetch entries; clear beats push.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import arm_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  fetch_entry_t       i_data,
    input  logic               i_pop,
    input  logic               i_clear,
    output fetch_entry_t       o_data,
    output logic [CNT_W-1:0]   o_count,
    output logic               o_full,
    output logic               o_empty
);

    fetch_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_count   = r_count;
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_do_push && !w_do_pop)
                r_count <= r_count + CNT_W'(1);
            else if (!w_do_push && w_do_pop)
                r_count <= r_count - CNT_W'(1);
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear)
            r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : PC owner and req/gnt/rvalid fetcher feeding a small buffer.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import arm_pkg::*;
#(
    parameter int                FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC   = arm_pkg::RESET_PC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INST_W-1:0]  imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INST_W-1:0]  out_inst
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t       r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic               r_drop;

    logic [CNT_W-1:0]   w_count;
    logic [CNT_W-1:0]   w_count_next;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_credit_next;
    fetch_entry_t       w_push_entry;
    fetch_entry_t       w_head;

    // r_pc already holds request address + 4 while waiting for the response.
    assign w_push       = (r_state == WAIT) && imem_rvalid && !r_drop && !branch_taken;
    assign w_pop        = !w_empty && out_ready;
    assign w_push_entry = '{pc: r_pc, inst: imem_rdata};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .i_clear (branch_taken),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_count_next = w_count;
        if (branch_taken)
            w_count_next = '0;
        else if (w_push && !w_pop)
            w_count_next = w_count + CNT_W'(1);
        else if (!w_push && w_pop)
            w_count_next = w_count - CNT_W'(1);
    end

    assign w_credit_next = (w_count_next < CNT_W'(FIFO_DEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_pc    <= word_align(RESET_PC);
            r_drop  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_full)
                        r_state <= REQ;
                end
                REQ: begin
                    if (imem_gnt) begin
                        r_state <= WAIT;
                        r_pc    <= r_pc + ADDR_W'(4);
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        r_drop  <= 1'b0;
                        r_state <= w_credit_next ? REQ : IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // A redirect overrides the PC; any response still owed is marked stale.
            if (branch_taken) begin
                r_pc <= word_align(branch_addr);
                if (((r_state == WAIT) && !imem_rvalid) || ((r_state == REQ) && imem_gnt))
                    r_drop <= 1'b1;
            end
        end
    end

    assign imem_req  = (r_state == REQ);
    assign imem_addr = r_pc;
    assign out_valid = !w_empty;
    assign out_pc    = w_head.pc;
    assign out_inst  = w_head.inst;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed self-checking bench for fetch_unit with a small imem model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk          = 1'b0;
    logic        rst          = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr  = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt     = 1'b0;
    logic        imem_rvalid  = 1'b0;
    logic [31:0] imem_rdata   = '0;
    logic        out_valid;
    logic        out_ready    = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    int n_cmp = 0;
    int n_bad = 0;

    int          gnt_delay = 0;
    int          rv_delay  = 0;
    int          m_wcnt    = 0;
    bit          m_pend    = 1'b0;
    int          m_rcnt    = 0;
    logic [31:0] m_raddr   = '0;

    int          m_cyc  = 0;
    int          n_rv   = 0;
    bit          h_req  = 1'b0;
    bit          h_out  = 1'b0;
    logic [31:0] h_addr = '0;
    logic [31:0] h_pc   = '0;
    logic [31:0] h_inst = '0;
    logic [31:0] g_q[$];
    logic [31:0] p_pc[$];
    logic [31:0] p_inst[$];
    int          p_cyc[$];

    fetch_unit #(
        .FIFO_DEPTH (2),
        .RESET_PC   (32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_inst     (out_inst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        g_q.delete();
        p_pc.delete();
        p_inst.delete();
        p_cyc.delete();
        n_rv = 0;
    endtask

    // Ends one time unit after a posedge, with reset just released.
    task automatic do_reset(input bit ready);
        rst          = 1'b0;
        branch_taken = 1'b0;
        out_ready    = ready;
        step(2);
        clear_logs();
        rst = 1'b1;
    endtask

    // Instruction memory: rdata = addr ^ E0000000, programmable gnt / rvalid delay.
    initial begin
        forever begin
            @(negedge clk);
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
            if (!rst) begin
                m_pend = 1'b0;
                m_wcnt = 0;
            end else begin
                if (m_pend) begin
                    if (m_rcnt == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = m_raddr ^ 32'hE000_0000;
                        m_pend      = 1'b0;
                    end else begin
                        m_rcnt--;
                    end
                end
                if (imem_req) begin
                    if (m_wcnt >= gnt_delay) begin
                        imem_gnt = 1'b1;
                        m_wcnt   = 0;
                        m_pend   = 1'b1;
                        m_rcnt   = rv_delay;
                        m_raddr  = imem_addr;
                    end else begin
                        m_wcnt++;
                    end
                end else begin
                    m_wcnt = 0;
                end
            end
        end
    end

    // Monitor just before each rising edge: logs grants/transfers, checks hold rules.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            m_cyc++;
            if (!rst) begin
                h_req = 1'b0;
                h_out = 1'b0;
            end else begin
                if (h_req)
                    chk("req_hold", {31'b0, imem_req, imem_addr}, {32'd1, h_addr});
                if (h_out)
                    chk("out_hold", {out_pc, out_inst}, {h_pc, h_inst});
                if (imem_req && imem_gnt) g_q.push_back(imem_addr);
                if (imem_rvalid) n_rv++;
                if (out_valid && out_ready) begin
                    p_pc.push_back(out_pc);
                    p_inst.push_back(out_inst);
                    p_cyc.push_back(m_cyc);
                end
                h_req  = imem_req && !imem_gnt && !branch_taken;
                h_addr = imem_addr;
                h_out  = out_valid && !out_ready && !branch_taken;
                h_pc   = out_pc;
                h_inst = out_inst;
            end
        end
    end

    initial begin
        // Reset values
        rst       = 1'b0;
        out_ready = 1'b1;
        step(2);
        chk("rst_req",   64'(imem_req),  64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_pc",    64'(out_pc),    64'd0);
        chk("rst_inst",  64'(out_inst),  64'd0);
        chk("rst_addr",  64'(imem_addr), 64'd0);
        clear_logs();
        rst = 1'b1;

        // Zero-wait streaming
        step(1);
        chk("s1_req",  64'(imem_req),  64'd1);
        chk("s1_addr", 64'(imem_addr), 64'd0);
        step(9);
        chk("s1_g0",   64'(g_q[0]),    64'h0);
        chk("s1_g1",   64'(g_q[1]),    64'h4);
        chk("s1_g2",   64'(g_q[2]),    64'h8);
        chk("s1_pc0",  64'(p_pc[0]),   64'h4);
        chk("s1_in0",  64'(p_inst[0]), 64'hE000_0000);
        chk("s1_pc1",  64'(p_pc[1]),   64'h8);
        chk("s1_in1",  64'(p_inst[1]), 64'hE000_0004);
        chk("s1_pc2",  64'(p_pc[2]),   64'hC);
        chk("s1_gap0", 64'(p_cyc[1] - p_cyc[0]), 64'd2);
        chk("s1_gap1", 64'(p_cyc[2] - p_cyc[1]), 64'd2);

        // Back-pressure: buffer fills, requests stop, head frozen
        do_reset(1'b0);
        step(10);
        chk("bp_req",   64'(imem_req),   64'd0);
        chk("bp_valid", 64'(out_valid),  64'd1);
        chk("bp_pc",    64'(out_pc),     64'h4);
        chk("bp_inst",  64'(out_inst),   64'hE000_0000);
        chk("bp_ngnt",  64'(g_q.size()), 64'd2);
        out_ready = 1'b1;
        step(10);
        chk("bp_pc0",  64'(p_pc[0]),   64'h4);
        chk("bp_pc1",  64'(p_pc[1]),   64'h8);
        chk("bp_pc2",  64'(p_pc[2]),   64'hC);
        chk("bp_in2",  64'(p_inst[2]), 64'hE000_0008);
        chk("bp_b2b",  64'(p_cyc[1] - p_cyc[0]), 64'd1);

        // Grant delayed by three cycles
        gnt_delay = 3;
        do_reset(1'b1);
        step(11);
        for (int i = 0; i < 4; i++) begin
            chk("gd_req",  64'(imem_req),  64'd1);
            chk("gd_addr", 64'(imem_addr), 64'h8);
            if (i < 3) step(1);
        end
        step(3);
        chk("gd_ngnt", 64'(g_q.size()), 64'd3);
        chk("gd_nrv",  64'(n_rv),       64'd3);
        chk("gd_g2",   64'(g_q[2]),     64'h8);
        chk("gd_pc1",  64'(p_pc[1]),    64'h8);
        gnt_delay = 0;

        // Redirect while waiting on a late response (unaligned target)
        rv_delay = 2;
        do_reset(1'b1);
        step(2);
        branch_taken = 1'b1;
        branch_addr  = 32'h0000_0102;
        step(1);
        branch_taken = 1'b0;
        step(2);
        chk("bw_req",   64'(imem_req),  64'd1);
        chk("bw_addr",  64'(imem_addr), 64'h100);
        chk("bw_valid", 64'(out_valid), 64'd0);
        step(4);
        chk("bw_valid2", 64'(out_valid), 64'd1);
        chk("bw_pc",     64'(out_pc),    64'h104);
        chk("bw_inst",   64'(out_inst),  64'hE000_0100);
        rv_delay = 0;

        // Redirect coinciding with rvalid and a full head, then a second redirect
        do_reset(1'b0);
        step(4);
        chk("br_pre_valid", 64'(out_valid), 64'd1);
        branch_taken = 1'b1;
        branch_addr  = 32'h0000_0180;
        step(1);
        chk("br_valid", 64'(out_valid), 64'd0);
        chk("br_pc",    64'(out_pc),    64'd0);
        chk("br_req",   64'(imem_req),  64'd1);
        chk("br_addr",  64'(imem_addr), 64'h180);
        branch_addr = 32'h0000_0200;
        out_ready   = 1'b1;
        step(1);
        branch_taken = 1'b0;
        step(1);
        chk("br2_req",  64'(imem_req),  64'd1);
        chk("br2_addr", 64'(imem_addr), 64'h200);
        step(7);
        chk("br2_pc0",  64'(p_pc[0]),   64'h204);
        chk("br2_in0",  64'(p_inst[0]), 64'hE000_0200);
        chk("br2_pc1",  64'(p_pc[1]),   64'h208);

        // Asynchronous reset in the middle of a fetch
        do_reset(1'b0);
        step(4);
        chk("ar_pre_valid", 64'(out_valid), 64'd1);
        rst = 1'b0;
        #1;
        chk("ar_valid", 64'(out_valid), 64'd0);
        chk("ar_pc",    64'(out_pc),    64'd0);
        chk("ar_inst",  64'(out_inst),  64'd0);
        chk("ar_req",   64'(imem_req),  64'd0);
        chk("ar_addr",  64'(imem_addr), 64'd0);
        do_reset(1'b1);
        step(1);
        chk("ar_req2",  64'(imem_req),  64'd1);
        chk("ar_addr2", 64'(imem_addr), 64'd0);
        step(3);
        chk("ar_pc0",   64'(p_pc[0]),   64'h4);
        chk("ar_in0",   64'(p_inst[0]), 64'hE000_0000);
        chk("ar_nrv",   64'(n_rv),      64'd1);

        // Redirect in REQ with grant, to the top of memory: PC wraps to 0
        do_reset(1'b1);
        step(1);
        branch_taken = 1'b1;
        branch_addr  = 32'hFFFF_FFFC;
        step(1);
        branch_taken = 1'b0;
        step(1);
        chk("wr_req",   64'(imem_req),    64'd1);
        chk("wr_addr",  64'(imem_addr),   64'hFFFF_FFFC);
        step(2);
        chk("wr_npop",  64'(p_pc.size()), 64'd0);
        chk("wr_valid", 64'(out_valid),   64'd1);
        chk("wr_pc",    64'(out_pc),      64'h0);
        chk("wr_inst",  64'(out_inst),    64'h1FFF_FFFC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
